// File: rtl/function_generator_pkg.sv
// Shared constants for the function generator: waveform codes, widths and the
// quarter-wave sine table Q[i] = round(127*sin(2*pi*i/256)), i = 0..64.
package function_generator_pkg;

  localparam int ACC_W    = 16;
  localparam int SAMPLE_W = 8;

  typedef enum logic [2:0] {
    WAVE_SAW_UP    = 3'd0,
    WAVE_SAW_DOWN  = 3'd1,
    WAVE_TRIANGLE  = 3'd2,
    WAVE_SQUARE    = 3'd3,
    WAVE_SINE      = 3'd4,
    WAVE_RECT_FULL = 3'd5,
    WAVE_RECT_HALF = 3'd6,
    WAVE_PULSE     = 3'd7
  } wave_e;

  localparam logic [6:0] SINE_Q [0:64] = '{
    7'd0,   7'd3,   7'd6,   7'd9,   7'd12,  7'd16,  7'd19,  7'd22,
    7'd25,  7'd28,  7'd31,  7'd34,  7'd37,  7'd40,  7'd43,  7'd46,
    7'd49,  7'd51,  7'd54,  7'd57,  7'd60,  7'd63,  7'd65,  7'd68,
    7'd71,  7'd73,  7'd76,  7'd78,  7'd81,  7'd83,  7'd85,  7'd88,
    7'd90,  7'd92,  7'd94,  7'd96,  7'd98,  7'd100, 7'd102, 7'd104,
    7'd106, 7'd107, 7'd109, 7'd111, 7'd112, 7'd113, 7'd115, 7'd116,
    7'd117, 7'd118, 7'd120, 7'd121, 7'd122, 7'd122, 7'd123, 7'd124,
    7'd125, 7'd125, 7'd126, 7'd126, 7'd126, 7'd127, 7'd127, 7'd127,
    7'd127
  };

endpackage

// File: rtl/sigma_delta_dac.sv
// First-order sigma-delta modulator: carry of sd + sample drives the bitstream.
// Bit output lags the sample by one cycle; free-running, no flow control.
module sigma_delta_dac
  import function_generator_pkg::*;
(
  input  logic                clk,
  input  logic                rst,
  input  logic [SAMPLE_W-1:0] sample,
  output logic                bit_out
);

  logic [SAMPLE_W-1:0] sd;
  logic [SAMPLE_W:0]   sum;

  assign sum = {1'b0, sd} + {1'b0, sample};

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      sd      <= '0;
      bit_out <= 1'b0;
    end else begin
      sd      <= sum[SAMPLE_W-1:0];
      bit_out <= sum[SAMPLE_W];
    end
  end

endmodule

// File: rtl/function_generator.sv
// Phase-accumulator waveform generator with eight selectable shapes and a sigma-delta DAC.
// out lags the phase by one cycle, dacOut lags out by one; free-running, no flow control.
module function_generator
  import function_generator_pkg::*;
(
  input  logic                clk,
  input  logic                rst,
  input  logic [9:0]          sel,
  output logic                dacOut,
  output logic [SAMPLE_W-1:0] out
);

  logic [ACC_W-1:0]    acc;
  logic [6:0]          step;
  logic [7:0]          phase;
  logic [1:0]          quad;
  logic [5:0]          idx;
  logic [6:0]          mag;
  logic [7:0]          tri_val;
  logic [SAMPLE_W-1:0] wave;
  wave_e               code;

  assign step  = sel[9:3];
  assign code  = wave_e'(sel[2:0]);
  assign phase = acc[ACC_W-1:ACC_W-8];
  assign quad  = phase[7:6];
  assign idx   = phase[5:0];

  // Odd quadrants read the table backwards so the quarter-wave mirrors.
  assign mag     = quad[0] ? SINE_Q[7'd64 - {1'b0, idx}] : SINE_Q[{1'b0, idx}];
  assign tri_val = {phase[6:0], 1'b0};

  always_comb begin
    wave = '0;
    case (code)
      WAVE_SAW_UP:    wave = phase;
      WAVE_SAW_DOWN:  wave = 8'd255 - phase;
      WAVE_TRIANGLE:  wave = phase[7] ? 8'd255 - tri_val : tri_val;
      WAVE_SQUARE:    wave = phase[7] ? 8'd0 : 8'd255;
      WAVE_SINE:      wave = quad[1] ? 8'd128 - {1'b0, mag} : 8'd128 + {1'b0, mag};
      WAVE_RECT_FULL: wave = {mag, 1'b0};
      WAVE_RECT_HALF: wave = quad[1] ? 8'd0 : {mag, 1'b0};
      WAVE_PULSE:     wave = (quad == 2'd0) ? 8'd255 : 8'd0;
      default:        wave = '0;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      acc <= '0;
      out <= '0;
    end else begin
      acc <= acc + {{(ACC_W-7){1'b0}}, step} + {{(ACC_W-1){1'b0}}, 1'b1};
      out <= wave;
    end
  end

  sigma_delta_dac u_dac (
    .clk     (clk),
    .rst     (rst),
    .sample  (out),
    .bit_out (dacOut)
  );

endmodule

// File: tb/tb_function_generator.sv
// Directed bench for function_generator; expected samples come from the waveform
// formulas with a sine table built in the bench using real arithmetic.
module tb_function_generator;

  logic       clk;
  logic       rst;
  logic [9:0] sel;
  logic       dacOut;
  logic [7:0] out;

  int n_tests;
  int n_fail;

  int         qt [0:64];
  logic [15:0] b_acc;
  logic [7:0]  b_out;
  logic [7:0]  b_sd;
  logic        b_dac;

  function_generator dut (
    .clk    (clk),
    .rst    (rst),
    .sel    (sel),
    .dacOut (dacOut),
    .out    (out)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic logic [7:0] wave(input logic [7:0] p, input logic [2:0] w);
    int q;
    int k;
    int m;
    int t;
    int r;
    q = int'(p[7:6]);
    k = int'(p[5:0]);
    m = (q == 1 || q == 3) ? qt[64 - k] : qt[k];
    t = int'(p[6:0]) * 2;
    case (w)
      3'd0:    r = int'(p);
      3'd1:    r = 255 - int'(p);
      3'd2:    r = p[7] ? 255 - t : t;
      3'd3:    r = p[7] ? 0 : 255;
      3'd4:    r = (q < 2) ? 128 + m : 128 - m;
      3'd5:    r = 2 * m;
      3'd6:    r = (q < 2) ? 2 * m : 0;
      default: r = (q == 0) ? 255 : 0;
    endcase
    return 8'(r);
  endfunction

  task automatic model_reset();
    b_acc = '0;
    b_out = '0;
    b_sd  = '0;
    b_dac = 1'b0;
  endtask

  // One clock with sel = s; leaves the bench at the following falling edge.
  task automatic tick(input logic [9:0] s, output logic [7:0] pre_p);
    logic [8:0] sum;
    sel = s;
    @(posedge clk);
    pre_p = b_acc[15:8];
    sum   = {1'b0, b_sd} + {1'b0, b_out};
    b_sd  = sum[7:0];
    b_dac = sum[8];
    b_out = wave(pre_p, s[2:0]);
    b_acc = b_acc + 16'(s[9:3]) + 16'd1;
    @(negedge clk);
  endtask

  task automatic test_reset();
    rst = 1'b0;
    sel = 10'h3FF;
    repeat (2) @(posedge clk);
    #2;
    n_tests++;
    if (out !== 8'd0) begin n_fail++; $display("FAIL reset_out got %0d want 0", out); end
    n_tests++;
    if (dacOut !== 1'b0) begin n_fail++; $display("FAIL reset_dac got %0b want 0", dacOut); end
    @(negedge clk);
    n_tests++;
    if (out !== 8'd0 || dacOut !== 1'b0) begin
      n_fail++; $display("FAIL reset_hold got out=%0d dac=%0b want 0/0", out, dacOut);
    end
    model_reset();
  endtask

  task automatic test_square();
    logic [7:0] p;
    logic [7:0] eo;
    logic       ed;
    sel = 10'd3;
    rst = 1'b1;
    for (int i = 1; i <= 65536; i++) begin
      tick(10'd3, p);
      eo = (i - 1 < 32768) ? 8'd255 : 8'd0;
      if (i == 1)          ed = 1'b0;
      else if (i <= 32769) ed = ((i - 2) % 256) != 0;
      else                 ed = 1'b0;
      n_tests++;
      if (out !== eo) begin n_fail++; $display("FAIL square_out cyc %0d got %0d want %0d", i, out, eo); end
      n_tests++;
      if (dacOut !== ed) begin n_fail++; $display("FAIL square_dac cyc %0d got %0b want %0b", i, dacOut, ed); end
    end
  endtask

  task automatic test_saw_up();
    logic [7:0] p;
    logic [7:0] eo;
    for (int k = 1; k <= 1024; k++) begin
      tick(10'd8, p);
      eo = 8'((k - 1) >> 7);
      n_tests++;
      if (out !== eo) begin n_fail++; $display("FAIL saw_up cyc %0d got %0d want %0d", k, out, eo); end
    end
  endtask

  task automatic test_saw_wrap();
    logic [7:0] p;
    logic [7:0] eo;
    int guard;
    guard = 0;
    while (b_acc != 16'hFF00 && guard < 1000) begin
      tick({7'd127, 3'd0}, p);
      guard++;
    end
    n_tests++;
    if (guard >= 1000) begin n_fail++; $display("FAIL saw_wrap_seek got timeout want acc=ff00"); end
    for (int j = 1; j <= 256; j++) begin
      tick(10'd8, p);
      eo = (j <= 128) ? 8'd255 : 8'd0;
      n_tests++;
      if (out !== eo) begin n_fail++; $display("FAIL saw_wrap cyc %0d got %0d want %0d", j, out, eo); end
    end
  endtask

  task automatic test_sine();
    logic [7:0] p;
    int hits;
    hits = 0;
    for (int j = 0; j < 512; j++) begin
      tick({7'd127, 3'd4}, p);
      if (p == 8'd0 || p == 8'd64 || p == 8'd128 || p == 8'd192) begin
        logic [7:0] e;
        e = (p == 8'd64) ? 8'd255 : (p == 8'd192) ? 8'd1 : 8'd128;
        hits++;
        n_tests++;
        if (out !== e) begin n_fail++; $display("FAIL sine_key p=%0d got %0d want %0d", p, out, e); end
      end
    end
    n_tests++;
    if (hits != 8) begin n_fail++; $display("FAIL sine_visits got %0d want 8", hits); end
  endtask

  task automatic test_sweep();
    logic [7:0] p;
    logic [7:0] e;
    for (int w = 0; w < 8; w++) begin
      for (int j = 0; j < 512; j++) begin
        tick({7'd127, 3'(w)}, p);
        e = wave(p, 3'(w));
        n_tests++;
        if (out !== e) begin n_fail++; $display("FAIL sweep_w%0d p=%0d got %0d want %0d", w, p, out, e); end
        n_tests++;
        if (dacOut !== b_dac) begin n_fail++; $display("FAIL sweep_dac_w%0d got %0b want %0b", w, dacOut, b_dac); end
        if (w == 5 && (p == 8'd64 || p == 8'd192 || p == 8'd0 || p == 8'd128)) begin
          e = (p == 8'd64 || p == 8'd192) ? 8'd254 : 8'd0;
          n_tests++;
          if (out !== e) begin n_fail++; $display("FAIL rect_full p=%0d got %0d want %0d", p, out, e); end
        end
        if (w == 6 && p >= 8'd128) begin
          n_tests++;
          if (out !== 8'd0) begin n_fail++; $display("FAIL rect_half p=%0d got %0d want 0", p, out); end
        end
      end
    end
  endtask

  task automatic test_sd_density();
    logic [7:0] p;
    logic       prev;
    int guard;
    guard = 0;
    while (b_acc != 16'h8000 && guard < 1000) begin
      tick({7'd127, 3'd0}, p);
      guard++;
    end
    n_tests++;
    if (guard >= 1000) begin n_fail++; $display("FAIL density_seek got timeout want acc=8000"); end
    prev = 1'b0;
    for (int j = 1; j <= 200; j++) begin
      tick(10'd0, p);
      n_tests++;
      if (out !== 8'd128) begin n_fail++; $display("FAIL density_out cyc %0d got %0d want 128", j, out); end
      if (j >= 3) begin
        n_tests++;
        if (dacOut !== ~prev) begin n_fail++; $display("FAIL density_alt cyc %0d got %0b want %0b", j, dacOut, ~prev); end
      end
      prev = dacOut;
    end
  endtask

  task automatic test_reset_mid();
    logic [7:0] p;
    repeat (37) tick({7'd127, 3'd4}, p);
    #2 rst = 1'b0;
    #1;
    n_tests++;
    if (out !== 8'd0 || dacOut !== 1'b0) begin
      n_fail++; $display("FAIL reset_mid_async got out=%0d dac=%0b want 0/0", out, dacOut);
    end
    repeat (2) @(posedge clk);
    @(negedge clk);
    n_tests++;
    if (out !== 8'd0 || dacOut !== 1'b0) begin
      n_fail++; $display("FAIL reset_mid_hold got out=%0d dac=%0b want 0/0", out, dacOut);
    end
    model_reset();
    rst = 1'b1;
    tick({7'd127, 3'd4}, p);
    n_tests++;
    if (out !== 8'd128) begin n_fail++; $display("FAIL reset_mid_release got %0d want 128", out); end
    tick({7'd127, 3'd4}, p);
    n_tests++;
    if (dacOut !== 1'b0) begin n_fail++; $display("FAIL reset_mid_dac got %0b want 0", dacOut); end
  endtask

  initial begin
    n_tests = 0;
    n_fail  = 0;
    rst     = 1'b0;
    sel     = '0;
    for (int i = 0; i <= 64; i++)
      qt[i] = $rtoi(127.0 * $sin(2.0 * 3.14159265358979 * real'(i) / 256.0) + 0.5);
    model_reset();
    test_reset();
    test_square();
    test_saw_up();
    test_saw_wrap();
    test_sine();
    test_sweep();
    test_sd_density();
    test_reset_mid();
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
